// File: rtl/ram.sv
// Single-port 16x16 scratch RAM with a registered read port.
// Write wins over read when both enables are high; reset clears the array and the output.
module ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    // Next-state: write has priority; a read only loads the output when no write is pending.
    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (wr_en) begin
            mem_d[address] = data_in;
        end else if (rd_en) begin
            data_out_d = mem_q[address];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the ram block.
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int tests;
    int fails;

    ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, return 1 ns after the next rising edge.
    task automatic do_cycle(input logic we, input logic re, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = we;
        rd_en   = re;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] addrs [3];
        addrs = '{4'd0, 4'd5, 4'd15};
        rst_n = 1'b0;
        #1;
        tests++;
        if (data_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_out: got %h expected %h", data_out, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b1, addrs[i], 16'h0);
            tests++;
            if (data_out !== 16'h0000) begin
                fails++;
                $display("FAIL reset_read addr %0d: got %h expected %h", addrs[i], data_out, 16'h0000);
            end
        end
    endtask

    task automatic test_write_read();
        do_cycle(1'b1, 1'b0, 4'd2, 16'd5);
        tests++;
        if (data_out !== 16'h0000) begin
            fails++;
            $display("FAIL write_hold: got %h expected %h", data_out, 16'h0000);
        end
        do_cycle(1'b0, 1'b1, 4'd2, 16'h0);
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL write_read addr 2: got %h expected %h", data_out, 16'd5);
        end
    endtask

    task automatic test_glitch();
        // wr_en pulsed mid-cycle but low at the edge: no write to addr 3
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; address = 4'd3; data_in = 16'h1234;
        #1 wr_en = 1'b1;
        #1 wr_en = 1'b0;
        @(posedge clk);
        #1;
        // wr 1->0->1 within 2 ns, high at the edge: write addr 2
        @(negedge clk);
        address = 4'd2; data_in = 16'd5; wr_en = 1'b1;
        #1 wr_en = 1'b0;
        #1 wr_en = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL glitch_wr_hold: got %h expected %h", data_out, 16'd5);
        end
        // rd_en pulsed mid-cycle, low at edge: output holds
        @(negedge clk);
        wr_en = 1'b0; address = 4'd3; rd_en = 1'b1;
        #1 rd_en = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL glitch_rd_hold: got %h expected %h", data_out, 16'd5);
        end
        do_cycle(1'b0, 1'b1, 4'd3, 16'h0);
        tests++;
        if (data_out !== 16'h0000) begin
            fails++;
            $display("FAIL glitch_no_write addr 3: got %h expected %h", data_out, 16'h0000);
        end
        do_cycle(1'b0, 1'b1, 4'd2, 16'h0);
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL glitch_edge_write addr 2: got %h expected %h", data_out, 16'd5);
        end
    endtask

    task automatic test_sequence();
        logic        we   [5];
        logic        re   [5];
        logic [3:0]  a    [5];
        logic [15:0] d    [5];
        logic [15:0] exp_v[5];
        we    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        re    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        a     = '{4'd5, 4'd5, 4'd0, 4'd2, 4'd5};
        d     = '{16'd0, 16'd2, 16'd0, 16'd0, 16'd0};
        exp_v = '{16'd0, 16'd0, 16'd0, 16'd5, 16'd2};
        for (int i = 0; i < 5; i++) begin
            do_cycle(we[i], re[i], a[i], d[i]);
            tests++;
            if (data_out !== exp_v[i]) begin
                fails++;
                $display("FAIL sequence step %0d addr %0d: got %h expected %h", i, a[i], data_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_both_enables();
        do_cycle(1'b0, 1'b1, 4'd2, 16'h0);
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL both_pre: got %h expected %h", data_out, 16'd5);
        end
        do_cycle(1'b1, 1'b1, 4'd7, 16'hBEEF);
        tests++;
        if (data_out !== 16'd5) begin
            fails++;
            $display("FAIL both_hold: got %h expected %h", data_out, 16'd5);
        end
        do_cycle(1'b0, 1'b1, 4'd7, 16'h0);
        tests++;
        if (data_out !== 16'hBEEF) begin
            fails++;
            $display("FAIL both_write addr 7: got %h expected %h", data_out, 16'hBEEF);
        end
    endtask

    task automatic test_back_to_back_and_async_reset();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'hA000 + 16'(i * 16'h0111);
            do_cycle(1'b1, 1'b0, 4'(i), v);
        end
        for (int i = 0; i < 16; i++) begin
            v = 16'hA000 + 16'(i * 16'h0111);
            do_cycle(1'b0, 1'b1, 4'(i), 16'h0);
            tests++;
            if (data_out !== v) begin
                fails++;
                $display("FAIL fill_read addr %0d: got %h expected %h", i, data_out, v);
            end
        end
        // pending write is set up, then reset lands mid-cycle before the edge
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; address = 4'd0; data_in = 16'hFFFF;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (data_out !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset_out: got %h expected %h", data_out, 16'h0000);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 1'b1, 4'(i), 16'h0);
            tests++;
            if (data_out !== 16'h0000) begin
                fails++;
                $display("FAIL post_reset_read addr %0d: got %h expected %h", i, data_out, 16'h0000);
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = 4'd0;
        data_in = 16'h0;
        #2;
        test_reset();
        test_write_read();
        test_glitch();
        test_sequence();
        test_both_enables();
        test_back_to_back_and_async_reset();
        do_cycle(1'b0, 1'b0, 4'd0, 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram.md
# ram

Single-port synchronous 16-word × 16-bit random-access memory with a registered read port. It serves as general-purpose scratch storage inside the datapath. Writes and reads are qualified by separate enables and share one address bus. All storage and the output register clear on an asynchronous active-low reset.

## Interface
- DATA_WIDTH, 16, width of each word and of data_in/data_out
- ADDR_WIDTH, 4, address width
- DEPTH, 2**ADDR_WIDTH (16), number of words; every address value is a valid location
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- wr_en  input  1  write enable, sampled at rising clk
- rd_en  input  1  read enable, sampled at rising clk
- address  input  ADDR_WIDTH  word address for both read and write
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data

## Operation
- Storage: DEPTH words of DATA_WIDTH bits each, mem[0..DEPTH-1].
- Reset (rst_n=0): takes effect immediately, without waiting for a clock edge.
  - Every mem word is cleared to 0.
  - data_out is cleared to 0.
  - The array and output stay cleared while rst_n is low. Clock edges and enables are ignored.
- Write: at rising clk with rst_n=1 and wr_en=1, mem[address] <= data_in.
- Read: at rising clk with rst_n=1, rd_en=1 and wr_en=0, data_out <= mem[address].
- Both enables high: the write takes priority.
  - mem[address] <= data_in.
  - The read is ignored and data_out holds its previous value.
- Neither enable high: no state change; data_out holds.
- data_out only changes on a qualifying read or on reset. It never follows address or data_in combinationally.
- Enable glitches between clock edges have no effect; only values at the rising edge matter.
- Address space is full-decoded: all 2**ADDR_WIDTH addresses map to distinct words, with no aliasing and no out-of-range case.

## Timing
- Write latency: data is stored at the enabling edge. A read issued on any later edge returns the new value.
- Read latency: 1 cycle. data_out is valid just after the rising edge at which rd_en=1 and wr_en=0 were sampled.
- Back-to-back reads to different addresses: each edge updates data_out, giving full throughput.
- Write then read of the same address on consecutive edges returns the written data.
- Reset released (rst_n rising) between edges: the first active edge is the next rising clk.
- Reset asserted mid-operation: any write not yet clocked is discarded, and data_out goes to 0 immediately.
- No handshake: enables are single-cycle strobes and the RAM is always ready.

## Test plan
- Reset, then read addresses 0, 5 and 15 -> data_out = 0 each cycle after the read edge.
- Write 5 to address 2. Then wr_en=0, rd_en=1, address=2 -> data_out = 5 one edge later.
- Pulse wr_en/rd_en briefly between clock edges (wr 1 -> 0 -> 1 within 2 ns, wr_en=1 at the edge), with address=2 and data_in=5 -> only the edge-sampled write occurs; mem[2]=5.
- Sequence:
  - Read address 5 -> 0.
  - Write 2 to address 5 with rd_en=0 -> data_out holds 0 during the write.
  - Read address 0 -> 0.
  - Read address 2 -> 5.
  - Read address 5 -> 2.
- wr_en=1 and rd_en=1 at address 7 with data_in=0xBEEF, data_out previously 5 -> data_out stays 5. A following read of address 7 returns 0xBEEF.
- Fill all 16 addresses with distinct values, then assert rst_n=0 asynchronously mid-cycle -> data_out = 0 immediately. After release, all 16 reads return 0.
